// File: rtl/axis_packet_deframer_if.sv
// Byte-stream ingress and assembled-packet egress bundle for the packet deframer.
// The slave modport is the deframer's view; master is the upstream/downstream side.
interface axis_packet_deframer_if #(
    parameter int unsigned MAX_PAYLOAD = 7
) ();
    logic [7:0]               s_axis_tdata;
    logic                     s_axis_tvalid;
    logic                     s_axis_tready;
    logic                     s_axis_tlast;
    logic [7:0]               m_pkt_opcode;
    logic [8*MAX_PAYLOAD-1:0] m_pkt_data;
    logic [2:0]               m_pkt_len;
    logic                     m_pkt_valid;
    logic                     m_pkt_ready;

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        output s_axis_tlast,
        output m_pkt_ready,
        input  s_axis_tready,
        input  m_pkt_opcode,
        input  m_pkt_data,
        input  m_pkt_len,
        input  m_pkt_valid
    );

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        input  s_axis_tlast,
        input  m_pkt_ready,
        output s_axis_tready,
        output m_pkt_opcode,
        output m_pkt_data,
        output m_pkt_len,
        output m_pkt_valid
    );
endinterface

// File: rtl/axis_packet_deframer.sv
// Assembles header + payload bytes from an 8-bit stream into one wide command word,
// dropping partial packets on inter-byte timeout or premature tlast.
module axis_packet_deframer #(
    parameter int unsigned MAX_PAYLOAD = 7,
    parameter logic [23:0] LEN_TABLE   = 24'hF1A440,
    parameter int unsigned TIMEOUT     = 1024,
    parameter bit          CHECK_LAST  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_packet_deframer_if.slave  bus,
    output logic                   status_timeout,
    output logic                   status_truncated,
    output logic                   status_bad_header
);

    localparam int unsigned DW       = 8 * MAX_PAYLOAD;
    localparam int unsigned CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [3:0]    MAX_LEN  = 4'(MAX_PAYLOAD);
    localparam bit            TMO_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t          r_state;
    logic [7:0]      r_opcode;
    logic [DW-1:0]   r_data;
    logic [2:0]      r_len;
    logic            r_valid;
    logic [2:0]      r_idx;
    logic [CW-1:0]   r_cnt;
    logic            r_tmo;
    logic            r_trunc;
    logic            r_bad;

    state_t          w_state_nxt;
    logic [7:0]      w_opcode_nxt;
    logic [DW-1:0]   w_data_nxt;
    logic [2:0]      w_len_nxt;
    logic            w_valid_nxt;
    logic [2:0]      w_idx_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_tmo_nxt;
    logic            w_trunc_nxt;
    logic            w_bad_nxt;

    logic            w_tready;
    logic            w_accept;
    logic [4:0]      w_lut_pos;
    logic [2:0]      w_hdr_len;
    logic            w_last_byte;

    // Ready depends on registered state only, never on m_pkt_ready.
    assign w_tready    = (r_state != ST_HOLD);
    assign w_accept    = bus.s_axis_tvalid && w_tready;
    assign w_lut_pos   = 5'(bus.s_axis_tdata[7:5]) * 5'd3;
    assign w_hdr_len   = LEN_TABLE[w_lut_pos +: 3];
    assign w_last_byte = (r_idx == (r_len - 3'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_opcode <= '0;
            r_data   <= '0;
            r_len    <= '0;
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_tmo    <= 1'b0;
            r_trunc  <= 1'b0;
            r_bad    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_opcode <= w_opcode_nxt;
            r_data   <= w_data_nxt;
            r_len    <= w_len_nxt;
            r_valid  <= w_valid_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_tmo    <= w_tmo_nxt;
            r_trunc  <= w_trunc_nxt;
            r_bad    <= w_bad_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_opcode_nxt = r_opcode;
        w_data_nxt   = r_data;
        w_len_nxt    = r_len;
        w_valid_nxt  = r_valid;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        w_tmo_nxt    = 1'b0;
        w_trunc_nxt  = 1'b0;
        w_bad_nxt    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if ({1'b0, w_hdr_len} > MAX_LEN) begin
                        w_bad_nxt = 1'b1;
                    end else if (CHECK_LAST && bus.s_axis_tlast && (w_hdr_len != 3'd0)) begin
                        w_trunc_nxt = 1'b1;
                    end else begin
                        w_opcode_nxt = bus.s_axis_tdata;
                        w_data_nxt   = '0;
                        w_len_nxt    = w_hdr_len;
                        w_idx_nxt    = '0;
                        w_cnt_nxt    = '0;
                        if (w_hdr_len == 3'd0) begin
                            w_state_nxt = ST_HOLD;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_PAYLOAD;
                        end
                    end
                end
            end

            ST_PAYLOAD: begin
                if (w_accept) begin
                    w_cnt_nxt = '0;
                    if (CHECK_LAST && bus.s_axis_tlast && !w_last_byte) begin
                        w_trunc_nxt = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                    end else begin
                        for (int unsigned i = 0; i < MAX_PAYLOAD; i++) begin
                            if (r_idx == 3'(i)) begin
                                w_data_nxt[8*i +: 8] = bus.s_axis_tdata;
                            end
                        end
                        if (w_last_byte) begin
                            w_state_nxt = ST_HOLD;
                            w_valid_nxt = 1'b1;
                            w_idx_nxt   = '0;
                        end else begin
                            w_idx_nxt = r_idx + 3'd1;
                        end
                    end
                end else if (TMO_EN) begin
                    // This idle cycle brings the count to TIMEOUT; an arriving byte would have won.
                    if (r_cnt == TMO_LAST) begin
                        w_tmo_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end

            ST_HOLD: begin
                if (bus.m_pkt_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign bus.s_axis_tready = w_tready;
    assign bus.m_pkt_opcode  = r_opcode;
    assign bus.m_pkt_data    = r_data;
    assign bus.m_pkt_len     = r_len;
    assign bus.m_pkt_valid   = r_valid;
    assign status_timeout    = r_tmo;
    assign status_truncated  = r_trunc;
    assign status_bad_header = r_bad;

endmodule

// File: tb/tb_axis_packet_deframer.sv
// Directed bench: DUT A uses default parameters, DUT B uses MAX_PAYLOAD=4, TIMEOUT=8, CHECK_LAST=1.
module tb_axis_packet_deframer;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    axis_packet_deframer_if #(.MAX_PAYLOAD(7)) if_a ();
    axis_packet_deframer_if #(.MAX_PAYLOAD(4)) if_b ();

    logic a_tmo, a_trunc, a_bad;
    logic b_tmo, b_trunc, b_bad;

    axis_packet_deframer #(
        .MAX_PAYLOAD(7), .LEN_TABLE(24'hF1A440), .TIMEOUT(1024), .CHECK_LAST(1'b0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave),
        .status_timeout(a_tmo), .status_truncated(a_trunc), .status_bad_header(a_bad)
    );

    axis_packet_deframer #(
        .MAX_PAYLOAD(4), .LEN_TABLE(24'hF1A440), .TIMEOUT(8), .CHECK_LAST(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave),
        .status_timeout(b_tmo), .status_truncated(b_trunc), .status_bad_header(b_bad)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d, input logic last);
        int unsigned n;
        n = 0;
        if_a.s_axis_tdata  = d;
        if_a.s_axis_tlast  = last;
        if_a.s_axis_tvalid = 1'b1;
        while (if_a.s_axis_tready !== 1'b1 && n < 32) begin step(); n++; end
        if (n >= 32) begin
            checks++; failures++;
            $display("FAIL send_a_stall: tready=%b required 1", if_a.s_axis_tready);
        end
        step();
        if_a.s_axis_tvalid = 1'b0;
        if_a.s_axis_tlast  = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic last);
        int unsigned n;
        n = 0;
        if_b.s_axis_tdata  = d;
        if_b.s_axis_tlast  = last;
        if_b.s_axis_tvalid = 1'b1;
        while (if_b.s_axis_tready !== 1'b1 && n < 32) begin step(); n++; end
        if (n >= 32) begin
            checks++; failures++;
            $display("FAIL send_b_stall: tready=%b required 1", if_b.s_axis_tready);
        end
        step();
        if_b.s_axis_tvalid = 1'b0;
        if_b.s_axis_tlast  = 1'b0;
    endtask

    task automatic ack_a();
        if_a.m_pkt_ready = 1'b1;
        step();
        if_a.m_pkt_ready = 1'b0;
    endtask

    task automatic ack_b();
        if_b.m_pkt_ready = 1'b1;
        step();
        if_b.m_pkt_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++; if (if_a.m_pkt_valid !== 1'b0) begin failures++; $display("FAIL rst_a_valid: got %b required 0", if_a.m_pkt_valid); end
        checks++; if ({if_a.m_pkt_opcode, if_a.m_pkt_data, if_a.m_pkt_len} !== 67'h0) begin failures++; $display("FAIL rst_a_payload: got %h required 0", {if_a.m_pkt_opcode, if_a.m_pkt_data, if_a.m_pkt_len}); end
        checks++; if (if_a.s_axis_tready !== 1'b1) begin failures++; $display("FAIL rst_a_tready: got %b required 1", if_a.s_axis_tready); end
        checks++; if ({a_tmo, a_trunc, a_bad, b_tmo, b_trunc, b_bad} !== 6'b0) begin failures++; $display("FAIL rst_status: got %b required 000000", {a_tmo, a_trunc, a_bad, b_tmo, b_trunc, b_bad}); end
        checks++; if ({if_b.m_pkt_valid, if_b.m_pkt_opcode, if_b.m_pkt_data, if_b.m_pkt_len} !== 44'h0) begin failures++; $display("FAIL rst_b_outputs: got %h required 0", {if_b.m_pkt_valid, if_b.m_pkt_opcode, if_b.m_pkt_data, if_b.m_pkt_len}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_short_packet();
        send_a(8'h40, 1'b0);
        checks++; if (if_a.m_pkt_valid !== 1'b0) begin failures++; $display("FAIL short_hdr_valid: got %b required 0", if_a.m_pkt_valid); end
        send_a(8'hAA, 1'b1);
        checks++; if (if_a.m_pkt_valid !== 1'b1) begin failures++; $display("FAIL short_valid: got %b required 1", if_a.m_pkt_valid); end
        checks++; if (if_a.m_pkt_opcode !== 8'h40) begin failures++; $display("FAIL short_opcode: got %h required 40", if_a.m_pkt_opcode); end
        checks++; if (if_a.m_pkt_len !== 3'd1) begin failures++; $display("FAIL short_len: got %0d required 1", if_a.m_pkt_len); end
        checks++; if (if_a.m_pkt_data !== 56'h000000000000AA) begin failures++; $display("FAIL short_data: got %h required 000000000000aa", if_a.m_pkt_data); end
        checks++; if (if_a.s_axis_tready !== 1'b0) begin failures++; $display("FAIL short_hold_tready: got %b required 0", if_a.s_axis_tready); end
        if_a.s_axis_tdata  = 8'hBB;
        if_a.s_axis_tvalid = 1'b1;
        step();
        checks++; if (if_a.m_pkt_valid !== 1'b1 || if_a.m_pkt_data !== 56'h000000000000AA) begin failures++; $display("FAIL short_blocked: valid=%b data=%h required 1/aa", if_a.m_pkt_valid, if_a.m_pkt_data); end
        ack_a();
        checks++; if (if_a.m_pkt_valid !== 1'b0 || if_a.s_axis_tready !== 1'b1) begin failures++; $display("FAIL short_ack: valid=%b tready=%b required 0/1", if_a.m_pkt_valid, if_a.s_axis_tready); end
        step();
        if_a.s_axis_tvalid = 1'b0;
        send_a(8'h01, 1'b0);
        send_a(8'h02, 1'b0);
        checks++; if (if_a.m_pkt_valid !== 1'b0) begin failures++; $display("FAIL bb_partial_valid: got %b required 0", if_a.m_pkt_valid); end
        send_a(8'h03, 1'b0);
        checks++; if (if_a.m_pkt_valid !== 1'b1 || if_a.m_pkt_opcode !== 8'hBB || if_a.m_pkt_len !== 3'd3) begin failures++; $display("FAIL bb_packet: valid=%b op=%h len=%0d required 1/bb/3", if_a.m_pkt_valid, if_a.m_pkt_opcode, if_a.m_pkt_len); end
        checks++; if (if_a.m_pkt_data !== 56'h00000000030201) begin failures++; $display("FAIL bb_data: got %h required 00000000030201", if_a.m_pkt_data); end
        ack_a();
    endtask

    task automatic test_long_back_to_back();
        send_a(8'hE0, 1'b0);
        for (int i = 1; i <= 7; i++) send_a(8'(i), 1'b0);
        checks++; if (if_a.m_pkt_valid !== 1'b1 || if_a.m_pkt_opcode !== 8'hE0 || if_a.m_pkt_len !== 3'd7) begin failures++; $display("FAIL long_packet: valid=%b op=%h len=%0d required 1/e0/7", if_a.m_pkt_valid, if_a.m_pkt_opcode, if_a.m_pkt_len); end
        checks++; if (if_a.m_pkt_data !== 56'h07060504030201) begin failures++; $display("FAIL long_data: got %h required 07060504030201", if_a.m_pkt_data); end
        if_a.s_axis_tdata  = 8'h40;
        if_a.s_axis_tvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if (if_a.m_pkt_valid !== 1'b1 || if_a.s_axis_tready !== 1'b0 || if_a.m_pkt_data !== 56'h07060504030201) begin failures++; $display("FAIL long_hold_c%0d: valid=%b tready=%b data=%h", c, if_a.m_pkt_valid, if_a.s_axis_tready, if_a.m_pkt_data); end
        end
        ack_a();
        checks++; if (if_a.m_pkt_valid !== 1'b0 || if_a.s_axis_tready !== 1'b1) begin failures++; $display("FAIL long_ack: valid=%b tready=%b required 0/1", if_a.m_pkt_valid, if_a.s_axis_tready); end
        step();
        if_a.s_axis_tvalid = 1'b0;
        checks++; if (if_a.m_pkt_valid !== 1'b0) begin failures++; $display("FAIL long_next_hdr_valid: got %b required 0", if_a.m_pkt_valid); end
        send_a(8'h5A, 1'b0);
        checks++; if (if_a.m_pkt_valid !== 1'b1 || if_a.m_pkt_opcode !== 8'h40 || if_a.m_pkt_data !== 56'h0000000000005A) begin failures++; $display("FAIL long_next_pkt: valid=%b op=%h data=%h required 1/40/5a", if_a.m_pkt_valid, if_a.m_pkt_opcode, if_a.m_pkt_data); end
        ack_a();
    endtask

    task automatic test_zero_len();
        send_a(8'h00, 1'b1);
        checks++; if (if_a.m_pkt_valid !== 1'b1 || if_a.m_pkt_len !== 3'd0 || if_a.m_pkt_opcode !== 8'h00) begin failures++; $display("FAIL zero_packet: valid=%b len=%0d op=%h required 1/0/00", if_a.m_pkt_valid, if_a.m_pkt_len, if_a.m_pkt_opcode); end
        checks++; if (if_a.m_pkt_data !== 56'h0) begin failures++; $display("FAIL zero_data: got %h required 0", if_a.m_pkt_data); end
        ack_a();
        if_a.m_pkt_ready   = 1'b1;
        if_a.s_axis_tdata  = 8'h00;
        if_a.s_axis_tvalid = 1'b1;
        step();
        checks++; if (if_a.m_pkt_valid !== 1'b1 || if_a.m_pkt_opcode !== 8'h00) begin failures++; $display("FAIL b2b_first: valid=%b op=%h required 1/00", if_a.m_pkt_valid, if_a.m_pkt_opcode); end
        if_a.s_axis_tdata = 8'h20;
        step();
        checks++; if (if_a.m_pkt_valid !== 1'b0 || if_a.s_axis_tready !== 1'b1) begin failures++; $display("FAIL b2b_bubble: valid=%b tready=%b required 0/1", if_a.m_pkt_valid, if_a.s_axis_tready); end
        step();
        if_a.s_axis_tvalid = 1'b0;
        checks++; if (if_a.m_pkt_valid !== 1'b1 || if_a.m_pkt_opcode !== 8'h20 || if_a.m_pkt_len !== 3'd0) begin failures++; $display("FAIL b2b_second: valid=%b op=%h len=%0d required 1/20/0", if_a.m_pkt_valid, if_a.m_pkt_opcode, if_a.m_pkt_len); end
        step();
        checks++; if (if_a.m_pkt_valid !== 1'b0) begin failures++; $display("FAIL b2b_done: got %b required 0", if_a.m_pkt_valid); end
        if_a.m_pkt_ready = 1'b0;
    endtask

    task automatic test_timeout();
        send_b(8'hA0, 1'b0);
        send_b(8'h11, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++; if (b_tmo !== 1'b0) begin failures++; $display("FAIL tmo_early_k%0d: got %b required 0", k, b_tmo); end
        end
        send_b(8'h22, 1'b0);
        checks++; if (b_tmo !== 1'b0) begin failures++; $display("FAIL tmo_byte_wins: got %b required 0", b_tmo); end
        send_b(8'h33, 1'b0);
        checks++; if (if_b.m_pkt_valid !== 1'b1 || if_b.m_pkt_data !== 32'h00332211 || if_b.m_pkt_len !== 3'd3) begin failures++; $display("FAIL tmo_survivor: valid=%b data=%h len=%0d required 1/00332211/3", if_b.m_pkt_valid, if_b.m_pkt_data, if_b.m_pkt_len); end
        ack_b();
        send_b(8'hA0, 1'b0);
        send_b(8'h11, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step();
            checks++; if (b_tmo !== (k == 8)) begin failures++; $display("FAIL tmo_pulse_k%0d: got %b required %b", k, b_tmo, (k == 8)); end
        end
        checks++; if (if_b.m_pkt_valid !== 1'b0 || if_b.s_axis_tready !== 1'b1) begin failures++; $display("FAIL tmo_idle: valid=%b tready=%b required 0/1", if_b.m_pkt_valid, if_b.s_axis_tready); end
        send_b(8'h40, 1'b0);
        send_b(8'h77, 1'b0);
        checks++; if (if_b.m_pkt_valid !== 1'b1 || if_b.m_pkt_opcode !== 8'h40 || if_b.m_pkt_data !== 32'h00000077) begin failures++; $display("FAIL tmo_reparse: valid=%b op=%h data=%h required 1/40/00000077", if_b.m_pkt_valid, if_b.m_pkt_opcode, if_b.m_pkt_data); end
        ack_b();
    endtask

    task automatic test_truncated();
        send_b(8'hC0, 1'b0);
        send_b(8'h11, 1'b0);
        send_b(8'h22, 1'b1);
        checks++; if (b_trunc !== 1'b1 || if_b.m_pkt_valid !== 1'b0 || if_b.s_axis_tready !== 1'b1) begin failures++; $display("FAIL trunc_pulse: trunc=%b valid=%b tready=%b required 1/0/1", b_trunc, if_b.m_pkt_valid, if_b.s_axis_tready); end
        step();
        checks++; if (b_trunc !== 1'b0 || if_b.m_pkt_valid !== 1'b0) begin failures++; $display("FAIL trunc_one_cycle: trunc=%b valid=%b required 0/0", b_trunc, if_b.m_pkt_valid); end
        send_b(8'h40, 1'b1);
        checks++; if (b_trunc !== 1'b1) begin failures++; $display("FAIL trunc_on_header: got %b required 1", b_trunc); end
        send_b(8'h00, 1'b1);
        checks++; if (b_trunc !== 1'b0 || if_b.m_pkt_valid !== 1'b1 || if_b.m_pkt_data !== 32'h0 || if_b.m_pkt_len !== 3'd0) begin failures++; $display("FAIL trunc_zero_len_ok: trunc=%b valid=%b data=%h len=%0d required 0/1/0/0", b_trunc, if_b.m_pkt_valid, if_b.m_pkt_data, if_b.m_pkt_len); end
        ack_b();
        send_b(8'h40, 1'b0);
        send_b(8'h99, 1'b1);
        checks++; if (b_trunc !== 1'b0 || if_b.m_pkt_valid !== 1'b1 || if_b.m_pkt_data !== 32'h00000099) begin failures++; $display("FAIL trunc_last_ok: trunc=%b valid=%b data=%h required 0/1/00000099", b_trunc, if_b.m_pkt_valid, if_b.m_pkt_data); end
        ack_b();
    endtask

    task automatic test_bad_header_reset();
        send_b(8'hE5, 1'b0);
        checks++; if (b_bad !== 1'b1 || if_b.m_pkt_valid !== 1'b0 || if_b.s_axis_tready !== 1'b1) begin failures++; $display("FAIL bad_pulse: bad=%b valid=%b tready=%b required 1/0/1", b_bad, if_b.m_pkt_valid, if_b.s_axis_tready); end
        step();
        checks++; if (b_bad !== 1'b0) begin failures++; $display("FAIL bad_one_cycle: got %b required 0", b_bad); end
        send_b(8'h40, 1'b0);
        send_b(8'h12, 1'b0);
        checks++; if (if_b.m_pkt_valid !== 1'b1 || if_b.m_pkt_opcode !== 8'h40 || if_b.m_pkt_data !== 32'h00000012) begin failures++; $display("FAIL bad_stays_idle: valid=%b op=%h data=%h required 1/40/00000012", if_b.m_pkt_valid, if_b.m_pkt_opcode, if_b.m_pkt_data); end
        ack_b();
        send_b(8'hA0, 1'b0);
        send_b(8'h55, 1'b0);
        rst = 1'b1;
        step();
        checks++; if ({if_b.m_pkt_valid, if_b.m_pkt_opcode, if_b.m_pkt_data, if_b.m_pkt_len} !== 44'h0) begin failures++; $display("FAIL mid_rst_outputs: got %h required 0", {if_b.m_pkt_valid, if_b.m_pkt_opcode, if_b.m_pkt_data, if_b.m_pkt_len}); end
        checks++; if ({b_tmo, b_trunc, b_bad} !== 3'b0 || if_b.s_axis_tready !== 1'b1) begin failures++; $display("FAIL mid_rst_status: status=%b tready=%b required 000/1", {b_tmo, b_trunc, b_bad}, if_b.s_axis_tready); end
        rst = 1'b0;
        send_b(8'h40, 1'b0);
        send_b(8'h66, 1'b0);
        checks++; if (if_b.m_pkt_valid !== 1'b1 || if_b.m_pkt_opcode !== 8'h40 || if_b.m_pkt_data !== 32'h00000066 || {b_tmo, b_trunc, b_bad} !== 3'b0) begin failures++; $display("FAIL post_rst_pkt: valid=%b op=%h data=%h status=%b required 1/40/00000066/000", if_b.m_pkt_valid, if_b.m_pkt_opcode, if_b.m_pkt_data, {b_tmo, b_trunc, b_bad}); end
        ack_b();
    endtask

    initial begin
        rst = 1'b1;
        if_a.s_axis_tdata = 8'h00; if_a.s_axis_tvalid = 1'b0; if_a.s_axis_tlast = 1'b0; if_a.m_pkt_ready = 1'b0;
        if_b.s_axis_tdata = 8'h00; if_b.s_axis_tvalid = 1'b0; if_b.s_axis_tlast = 1'b0; if_b.m_pkt_ready = 1'b0;
        test_reset();
        test_short_packet();
        test_long_back_to_back();
        test_zero_len();
        test_timeout();
        test_truncated();
        test_bad_header_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
